geofence_driver: RTL and testbench
==================================

# geofence_driver

Upstream-facing initiator for the `geofence` core. It accepts object records as a point stream with a valid/ready handshake and buffers up to two complete objects. It drives each object into `geofence` over that core's X/Y sampling protocol, waits for the core's `valid` pulse, and returns the `is_inside` verdict on a result handshake. A watchdog covers a core that never answers.

## Interface
Parameters:
- COORD_W, 11, coordinate width; must match `geofence` X/Y.
- TIMEOUT, 64, max cycles in WAIT before a forced timeout result.
- ID_W, 8, result sequence-number width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low.
- in_valid  in  1  point-stream valid.
- in_ready  out  1  point-stream ready.
- in_x, in_y  in  COORD_W each  point coordinates. Per object: P0 = target, P1..P5 = fence vertices, in any order.
- gf_reset  out  1  active-high reset to `geofence`, registered.
- gf_x, gf_y  out  COORD_W each  registered, drive `geofence` X/Y.
- gf_valid  in  1  `geofence` valid.
- gf_inside  in  1  `geofence` is_inside.
- res_valid  out  1  result valid; held until accepted.
- res_ready  in  1  result ready.
- res_inside  out  1  verdict; 0 on timeout.
- res_timeout  out  1  result produced by the watchdog.
- res_id  out  ID_W  object sequence number; starts at 0 and wraps to 0 after all-ones.

## Operation
- Object buffer: 2 slots of 6 points each, ping-pong.
  - Write pointer and point index 0..5 advance on `in_valid && in_ready`.
  - A slot becomes "full" on the edge that accepts its P5.
  - `in_ready = ~full[wr_slot]`.
- The FSM has four states: HOLD, FEED, WAIT, REPORT.
- HOLD: `gf_reset=1`, `gf_x/gf_y=0`.
  - Moves to FEED when `full[rd_slot] && !res_valid`.
  - On that edge: `gf_reset<=0`, `gf_x/y<=P0`, `k<=0`.
- FEED: on each edge with `k<5`, drive `P(k+1)` and increment `k`.
  - On the edge with `k==5`:
    - clear `full[rd_slot]`;
    - toggle `rd_slot`;
    - set `gf_x/y<=0`;
    - clear the watchdog;
    - go to WAIT.
- WAIT: the watchdog increments each cycle.
  - If `gf_valid` is high, capture `gf_inside` into `res_inside`, set `res_timeout=0` and `res_valid=1`, assert `gf_reset<=1`, and go to REPORT.
  - Otherwise, when the watchdog reaches `TIMEOUT-1`, set `res_inside=0`, `res_timeout=1` and `res_valid=1`, assert `gf_reset<=1`, and go to REPORT.
  - `gf_valid` wins if both conditions occur in the same cycle.
- REPORT: go to HOLD unconditionally on the next edge. `res_valid` stays set until `res_valid && res_ready`.
  - `res_id` increments on every handshake.
  - `res_valid` is cleared on the handshake.
- The core is re-reset before every object, so there is never a dependence on its internal return-to-input behaviour.
- Simultaneous events:
  - Slot commit and launch decisions are registered, so an object committed on edge N launches no earlier than edge N+1.
  - Writes to one slot while the other slot is being fed are legal.
- Reset asserted mid-operation discards buffered and partial objects and any pending result.

## Timing
- Reset values:
  - `in_ready=1`
  - `gf_reset=1`
  - `gf_x=gf_y=0`
  - `res_valid=0`, `res_inside=0`, `res_timeout=0`, `res_id=0`
  - FSM in HOLD, both slots empty.
- Launch edge L: `gf_reset` falls and P0 appears. `geofence` samples P0..P5 on edges L+1..L+6.
- FEED lasts exactly 6 cycles, and `gf_x/y` changes only on edges.
- Result latency from `gf_valid` sampled high to `res_valid` high: 1 cycle.
- Minimum spacing between launches: 9 cycles plus the core compute time (HOLD 1, FEED 6, WAIT ≥1, REPORT 1).
- Back-pressure: while `res_valid && !res_ready`, HOLD does not launch. Input continues until both slots are full.

## Structure
- `geofence_pkg`:
  - `COORD_W`
  - `NUM_PTS=6`
  - `point_t` struct {x,y}
  - `drv_state_t` enum {HOLD, FEED, WAIT, REPORT}
- Sub-module `geofence_obj_buf`:
  - 2×6 `point_t` storage;
  - write pointer/index;
  - full flags;
  - read port addressed by (`rd_slot`, `k`);
  - a `release` input.
- The top level holds the FSM, watchdog, result register, and output registers.

## Test plan
- Testbench fence used in the first three scenarios: vertices (2,2), (10,2), (12,8), (6,12), (1,8), fed in the order (6,12), (2,2), (12,8), (1,8), (10,2).
- Single object, inside: target (6,6) with the fence above, driven into a real `geofence` → exactly one result with `res_inside=1`, `res_timeout=0`, `res_id=0`. `gf_x/y` carries P0..P5 on six consecutive cycles immediately after `gf_reset` falls.
- Single object, outside: target (20,20), same fence → `res_inside=0`, `res_id=1`.
- Back-to-back with back-pressure: three objects streamed without gaps (inside, outside, inside) with `res_ready=0` for 50 cycles.
  - `in_ready` falls after the 12th point is accepted.
  - Results then arrive in order 1, 0, 1 with ids 0, 1, 2.
  - No launch occurs while `res_valid` is pending.
- Timeout: model `gf_valid` stuck at 0 → after FEED, exactly 64 cycles of WAIT, then `res_timeout=1`, `res_inside=0`, and `gf_reset` reasserted.
- Reset mid-FEED: assert `reset` low at k=3.
  - All outputs return to their reset values asynchronously.
  - After release, a fresh object gives a correct result with `res_id=0`.
- Race: `gf_valid` high on the same cycle the watchdog hits `TIMEOUT-1` → `res_timeout=0` and `res_inside` takes `gf_inside`.

Source files
------------

// File: rtl/geofence_pkg.sv
// Shared types for the geofence driver: point record, buffer geometry and
// the driver FSM state encoding.
package geofence_pkg;

    localparam int COORD_W = 11;
    localparam int NUM_PTS = 6;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        FEED   = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } drv_state_t;

endpackage

// File: rtl/geofence_obj_buf.sv
// Two-slot ping-pong object buffer: six points per slot, written in arrival
// order, read by (slot, index) while the other slot may still be filling.
module geofence_obj_buf
    import geofence_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid_i,
    input  point_t     wr_pt_i,
    output logic       wr_ready_o,
    input  logic       rd_slot_i,
    input  logic [2:0] rd_idx_i,
    output point_t     rd_pt_o,
    output logic [1:0] full_o,
    input  logic       release_i
);

    point_t     mem_q [2][NUM_PTS];
    logic       wr_slot_q, wr_slot_d;
    logic [2:0] wr_idx_q, wr_idx_d;
    logic [1:0] full_q, full_d;
    logic       wr_fire;

    assign wr_ready_o = ~full_q[wr_slot_q];
    assign wr_fire    = wr_valid_i && wr_ready_o;
    assign full_o     = full_q;
    assign rd_pt_o    = mem_q[rd_slot_i][rd_idx_i];

    // A write only ever targets an empty slot and a release only a full one,
    // so the two updates of full_d never collide on the same bit.
    always_comb begin
        wr_slot_d = wr_slot_q;
        wr_idx_d  = wr_idx_q;
        full_d    = full_q;
        if (release_i) begin
            full_d[rd_slot_i] = 1'b0;
        end
        if (wr_fire) begin
            if (wr_idx_q == 3'(NUM_PTS - 1)) begin
                wr_idx_d          = 3'd0;
                wr_slot_d         = ~wr_slot_q;
                full_d[wr_slot_q] = 1'b1;
            end else begin
                wr_idx_d = wr_idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_slot_q <= 1'b0;
            wr_idx_q  <= 3'd0;
            full_q    <= 2'b00;
        end else begin
            wr_slot_q <= wr_slot_d;
            wr_idx_q  <= wr_idx_d;
            full_q    <= full_d;
        end
    end

    // Storage needs no reset: the full flags gate every read.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_slot_q][wr_idx_q] <= wr_pt_i;
        end
    end

endmodule

// File: rtl/geofence_driver.sv
// Initiator for the geofence core: buffers objects, feeds P0..P5 on
// consecutive edges, waits for the verdict under a watchdog, reports it.
module geofence_driver #(
    parameter int COORD_W = geofence_pkg::COORD_W,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               gf_reset,
    output logic [COORD_W-1:0] gf_x,
    output logic [COORD_W-1:0] gf_y,
    input  logic               gf_valid,
    input  logic               gf_inside,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_inside,
    output logic               res_timeout,
    output logic [ID_W-1:0]    res_id
);

    import geofence_pkg::*;

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    drv_state_t         state_q, state_d;
    logic [2:0]         k_q, k_d;
    logic               rd_slot_q, rd_slot_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               gf_reset_q, gf_reset_d;
    logic [COORD_W-1:0] gf_x_q, gf_x_d, gf_y_q, gf_y_d;
    logic               res_valid_q, res_valid_d;
    logic               res_inside_q, res_inside_d;
    logic               res_timeout_q, res_timeout_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;

    point_t             wr_pt, rd_pt;
    logic [2:0]         rd_idx;
    logic [1:0]         buf_full;
    logic               buf_release;

    assign wr_pt.x = in_x;
    assign wr_pt.y = in_y;
    // During FEED the read port looks one point ahead of k; in HOLD it shows P0.
    assign rd_idx  = (state_q == FEED && k_q != 3'(NUM_PTS - 1)) ? k_q + 3'd1 : 3'd0;

    geofence_obj_buf u_buf (
        .clk        (clk),
        .rst_n      (reset),
        .wr_valid_i (in_valid),
        .wr_pt_i    (wr_pt),
        .wr_ready_o (in_ready),
        .rd_slot_i  (rd_slot_q),
        .rd_idx_i   (rd_idx),
        .rd_pt_o    (rd_pt),
        .full_o     (buf_full),
        .release_i  (buf_release)
    );

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        rd_slot_d     = rd_slot_q;
        wd_d          = wd_q;
        gf_reset_d    = gf_reset_q;
        gf_x_d        = gf_x_q;
        gf_y_d        = gf_y_q;
        res_valid_d   = res_valid_q;
        res_inside_d  = res_inside_q;
        res_timeout_d = res_timeout_q;
        res_id_d      = res_id_q;
        buf_release   = 1'b0;

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            res_id_d    = res_id_q + 1'b1;
        end

        unique case (state_q)
            HOLD: begin
                gf_reset_d = 1'b1;
                gf_x_d     = '0;
                gf_y_d     = '0;
                if (buf_full[rd_slot_q] && !res_valid_q) begin
                    state_d    = FEED;
                    gf_reset_d = 1'b0;
                    gf_x_d     = rd_pt.x;
                    gf_y_d     = rd_pt.y;
                    k_d        = 3'd0;
                end
            end
            FEED: begin
                if (k_q != 3'(NUM_PTS - 1)) begin
                    gf_x_d = rd_pt.x;
                    gf_y_d = rd_pt.y;
                    k_d    = k_q + 3'd1;
                end else begin
                    buf_release = 1'b1;
                    rd_slot_d   = ~rd_slot_q;
                    gf_x_d      = '0;
                    gf_y_d      = '0;
                    wd_d        = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                // A real answer beats the watchdog when both land together.
                if (gf_valid) begin
                    res_inside_d  = gf_inside;
                    res_timeout_d = 1'b0;
                    res_valid_d   = 1'b1;
                    gf_reset_d    = 1'b1;
                    state_d       = REPORT;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    res_inside_d  = 1'b0;
                    res_timeout_d = 1'b1;
                    res_valid_d   = 1'b1;
                    gf_reset_d    = 1'b1;
                    state_d       = REPORT;
                end
            end
            REPORT: begin
                state_d = HOLD;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= HOLD;
            k_q           <= 3'd0;
            rd_slot_q     <= 1'b0;
            wd_q          <= '0;
            gf_reset_q    <= 1'b1;
            gf_x_q        <= '0;
            gf_y_q        <= '0;
            res_valid_q   <= 1'b0;
            res_inside_q  <= 1'b0;
            res_timeout_q <= 1'b0;
            res_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            rd_slot_q     <= rd_slot_d;
            wd_q          <= wd_d;
            gf_reset_q    <= gf_reset_d;
            gf_x_q        <= gf_x_d;
            gf_y_q        <= gf_y_d;
            res_valid_q   <= res_valid_d;
            res_inside_q  <= res_inside_d;
            res_timeout_q <= res_timeout_d;
            res_id_q      <= res_id_d;
        end
    end

    assign gf_reset    = gf_reset_q;
    assign gf_x        = gf_x_q;
    assign gf_y        = gf_y_q;
    assign res_valid   = res_valid_q;
    assign res_inside  = res_inside_q;
    assign res_timeout = res_timeout_q;
    assign res_id      = res_id_q;

endmodule

// File: tb/tb_geofence_driver.sv
// Bench for geofence_driver with a behavioural geofence stand-in whose answer
// latency is programmable per object (or never, to exercise the watchdog).
`timescale 1ns/1ps
module tb_geofence_driver;

    localparam int COORD_W = 11;
    localparam int TIMEOUT = 64;
    localparam int ID_W    = 8;
    localparam int RW      = ID_W + 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [COORD_W-1:0] in_x = '0, in_y = '0;
    logic               gf_reset;
    logic [COORD_W-1:0] gf_x, gf_y;
    logic               gf_valid = 1'b0, gf_inside = 1'b0;
    logic               res_valid, res_ready = 1'b0;
    logic               res_inside, res_timeout;
    logic [ID_W-1:0]    res_id;

    always #5 clk = ~clk;

    geofence_driver #(.COORD_W(COORD_W), .TIMEOUT(TIMEOUT), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .gf_reset(gf_reset), .gf_x(gf_x), .gf_y(gf_y),
        .gf_valid(gf_valid), .gf_inside(gf_inside),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_inside(res_inside), .res_timeout(res_timeout), .res_id(res_id)
    );

    int tests = 0, fails = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];

    // Fence vertices in the order they are streamed.
    logic [COORD_W-1:0] fx[5] = '{11'd6, 11'd2, 11'd12, 11'd1, 11'd10};
    logic [COORD_W-1:0] fy[5] = '{11'd12, 11'd2, 11'd8, 11'd8, 11'd2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- geofence stand-in ----------------
    int core_cnt = 0, core_valid_at = 10, core_last_cnt = 0, launches = 0;
    logic [COORD_W-1:0] rec_x[6], rec_y[6];

    function automatic logic model_inside(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py);
        int vx[5];
        int vy[5];
        int ax, ay, bx, by, cr;
        vx = '{2, 10, 12, 6, 1};
        vy = '{2, 2, 8, 12, 8};
        for (int i = 0; i < 5; i++) begin
            ax = vx[i]; ay = vy[i];
            bx = vx[(i + 1) % 5]; by = vy[(i + 1) % 5];
            cr = (bx - ax) * (int'(py) - ay) - (by - ay) * (int'(px) - ax);
            if (cr < 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (gf_reset) begin
                if (core_cnt > 0) core_last_cnt = core_cnt;
                core_cnt  = 0;
                gf_valid  = 1'b0;
                gf_inside = 1'b0;
            end else begin
                if (core_cnt == 0) launches++;
                core_cnt++;
                if (core_cnt <= 6) begin
                    rec_x[core_cnt - 1] = gf_x;
                    rec_y[core_cnt - 1] = gf_y;
                end
                gf_valid  = (core_valid_at != 0) && (core_cnt == core_valid_at);
                gf_inside = gf_valid ? model_inside(rec_x[0], rec_y[0]) : 1'b0;
            end
        end
    end

    // ---------------- result collector ----------------
    always @(negedge clk) begin
        if (reset && res_valid && res_ready) got_q.push_back({res_id, res_inside, res_timeout});
    end

    // ---------------- driver tasks ----------------
    task automatic send_pt(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL in_ready_wait: got 0 expected 1 within 500 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_obj(input logic [COORD_W-1:0] tx, input logic [COORD_W-1:0] ty);
        send_pt(tx, ty);
        for (int i = 0; i < 5; i++) send_pt(fx[i], fy[i]);
    endtask

    task automatic wait_results(input int n);
        int cyc;
        cyc = 0;
        while (got_q.size() < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic score(input string name);
        logic [RW-1:0] e, g;
        e = exp_q.pop_front();
        if (got_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got no result expected %0h", name, e);
        end else begin
            g = got_q.pop_front();
            check(name, g, e);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        got_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_gf_reset"}, gf_reset, 1);
        check({tag, "_gf_x"}, gf_x, 0);
        check({tag, "_gf_y"}, gf_y, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_inside"}, res_inside, 0);
        check({tag, "_res_timeout"}, res_timeout, 0);
        check({tag, "_res_id"}, res_id, 0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [COORD_W-1:0] tx, ty;
        int                 valid_at;    // stand-in cycle count of its answer; 0 = never
        logic               exp_inside;
        logic               exp_timeout;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base;
        int exp_id;
        int exp_wait;
        logic trace_ok;

        vecs[0] = '{11'd6,  11'd6,  10, 1'b1, 1'b0};
        vecs[1] = '{11'd20, 11'd20, 10, 1'b0, 1'b0};
        vecs[2] = '{11'd3,  11'd3,  7,  1'b1, 1'b0};
        vecs[3] = '{11'd6,  11'd6,  0,  1'b0, 1'b1};
        vecs[4] = '{11'd5,  11'd5,  70, 1'b1, 1'b0};
        vecs[5] = '{11'd20, 11'd20, 69, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        res_ready = 1'b1;
        exp_id = 0;
        foreach (vecs[v]) begin
            core_valid_at = vecs[v].valid_at;
            exp_q.push_back({ID_W'(exp_id), vecs[v].exp_inside, vecs[v].exp_timeout});
            send_obj(vecs[v].tx, vecs[v].ty);
            wait_results(1);
            score($sformatf("vec%0d_result", v));
            exp_id++;
            repeat (2) @(negedge clk);
            trace_ok = (rec_x[0] == vecs[v].tx) && (rec_y[0] == vecs[v].ty);
            for (int i = 0; i < 5; i++)
                trace_ok = trace_ok && (rec_x[i + 1] == fx[i]) && (rec_y[i + 1] == fy[i]);
            check($sformatf("vec%0d_trace", v), trace_ok, 1);
            exp_wait = (vecs[v].valid_at == 0) ? TIMEOUT : vecs[v].valid_at - 6;
            check($sformatf("vec%0d_wait_cycles", v), core_last_cnt - 6, exp_wait);
            check($sformatf("vec%0d_gf_reset", v), gf_reset, 1);
            @(posedge clk);
            #1;
        end

        // Three objects back to back while results are held off.
        apply_reset();
        res_ready = 1'b0;
        core_valid_at = 10;
        base = launches;
        send_obj(11'd6, 11'd6);
        send_obj(11'd20, 11'd20);
        @(negedge clk);
        check("bp_in_ready_after_12", in_ready, 0);
        send_obj(11'd5, 11'd5);
        repeat (30) @(negedge clk);
        check("bp_in_ready_both_full", in_ready, 0);
        check("bp_res_valid_held", res_valid, 1);
        check("bp_launches_while_pending", launches - base, 1);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        exp_q.push_back({8'd0, 1'b1, 1'b0});
        exp_q.push_back({8'd1, 1'b0, 1'b0});
        exp_q.push_back({8'd2, 1'b1, 1'b0});
        wait_results(3);
        score("bp_result0");
        score("bp_result1");
        score("bp_result2");
        check("bp_launches_total", launches - base, 3);

        // Reset asserted in the middle of FEED, at k=3.
        @(posedge clk);
        #1;
        send_obj(11'd20, 11'd20);
        base = 0;
        do begin
            @(negedge clk);
            #1;
            base++;
        end while (core_cnt != 4 && base < 50);
        check("midreset_reached_k3", core_cnt, 4);
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        got_q.delete();
        @(posedge clk);
        #1;
        exp_q.push_back({8'd0, 1'b1, 1'b0});
        send_obj(11'd6, 11'd6);
        wait_results(1);
        score("midreset_fresh_result");
        repeat (4) @(negedge clk);
        check("midreset_no_extra_result", got_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL global_timeout: simulation did not finish within 500 us");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "global timeout");
    end

endmodule
